// File: rtl/t05_code_unpack_pkg.sv
// Shared t05 definitions: code/byte widths, buffer width and the packer/unpacker state encoding.
package t05_code_unpack_pkg;

  localparam int unsigned T05_CODE_W = 7;
  localparam int unsigned T05_BYTE_W = 8;
  localparam int unsigned T05_BUF_W  = T05_CODE_W + T05_BYTE_W;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } t05_state_e;

endpackage

// File: rtl/t05_code_unpack.sv
// Byte-to-code unpacker: MSB-first bit buffer refilled by bytes, drained as CODE_W-bit codes,
// with an end-of-stream tail that flushes the buffer and reports the discarded residue.
module t05_code_unpack
  import t05_code_unpack_pkg::*;
#(
  parameter int unsigned CODE_W = T05_CODE_W,
  parameter int unsigned BYTE_W = T05_BYTE_W,
  localparam int unsigned BUF_W = CODE_W + BYTE_W,
  localparam int unsigned CNT_W = $clog2(BUF_W + 1),
  localparam int unsigned TC_W  = $clog2(CODE_W + 1)
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              en,
  input  logic              clear,
  input  logic [BYTE_W-1:0] byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  input  logic [CODE_W-1:0] tail_data,
  input  logic [TC_W-1:0]   tail_count,
  input  logic              tail_valid,
  output logic              tail_ready,
  output logic [CODE_W-1:0] code_out,
  output logic              code_valid,
  input  logic              code_ready,
  output logic              done,
  output logic [TC_W-1:0]   residue_count
);

  localparam logic [CNT_W-1:0] CODE_N = CNT_W'(CODE_W);
  localparam logic [CNT_W-1:0] BYTE_N = CNT_W'(BYTE_W);

  t05_state_e        state_q, state_d;
  logic [BUF_W-1:0]  buf_q, buf_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              done_q, done_d;
  logic [TC_W-1:0]   res_q, res_d;
  logic              run_ok_q, run_ok_d;

  logic [BUF_W-1:0]  aligned;
  logic [CNT_W-1:0]  cnt_left;
  logic [CODE_W-1:0] tail_mask;
  logic              room;

  always_comb begin
    state_d  = state_q;
    buf_d    = buf_q;
    cnt_d    = cnt_q;
    done_d   = done_q;
    res_d    = res_q;
    run_ok_d = run_ok_q;

    // run_ok keeps both ready outputs low until the first enabled cycle after reset
    room       = run_ok_q && (state_q == ST_RUN) && (cnt_q < CODE_N) && !clear;
    byte_ready = room;
    tail_ready = room && !byte_valid;
    code_valid = (state_q != ST_DONE) && (cnt_q >= CODE_N);

    aligned  = buf_q >> (cnt_q - CODE_N);
    code_out = code_valid ? aligned[CODE_W-1:0] : '0;

    cnt_left  = cnt_q - CODE_N;
    tail_mask = ~({CODE_W{1'b1}} << tail_count);

    if (en) begin
      run_ok_d = 1'b1;
      done_d   = 1'b0;
      if (clear) begin
        buf_d   = '0;
        cnt_d   = '0;
        state_d = ST_RUN;
      end else begin
        unique case (state_q)
          ST_RUN: begin
            // byte/tail acceptance needs cnt < CODE_W, so it never overlaps a code transfer
            if (code_valid && code_ready) begin
              cnt_d = cnt_left;
              buf_d = buf_q & ~({BUF_W{1'b1}} << cnt_left);
            end else if (byte_ready && byte_valid) begin
              buf_d = {buf_q[BUF_W-BYTE_W-1:0], byte_in};
              cnt_d = cnt_q + BYTE_N;
            end else if (tail_ready && tail_valid) begin
              buf_d   = (buf_q << tail_count) | BUF_W'(tail_data & tail_mask);
              cnt_d   = cnt_q + CNT_W'(tail_count);
              state_d = ST_DRAIN;
            end
          end
          ST_DRAIN: begin
            if (code_valid) begin
              if (code_ready) begin
                cnt_d = cnt_left;
                buf_d = buf_q & ~({BUF_W{1'b1}} << cnt_left);
              end
            end else begin
              done_d  = 1'b1;
              res_d   = cnt_q[TC_W-1:0];
              buf_d   = '0;
              cnt_d   = '0;
              state_d = ST_DONE;
            end
          end
          ST_DONE:  state_d = ST_RUN;
          default:  state_d = ST_RUN;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q  <= ST_RUN;
      buf_q    <= '0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      res_q    <= '0;
      run_ok_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      buf_q    <= buf_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
      res_q    <= res_d;
      run_ok_q <= run_ok_d;
    end
  end

  assign done          = done_q;
  assign residue_count = res_q;

endmodule

// File: tb/tb_t05_code_unpack.sv
// Directed bench for t05_code_unpack: table of byte/tail streams plus hand-timed corner sequences.
module tb_t05_code_unpack;

  logic       clk = 1'b0;
  logic       nrst, en, clear;
  logic [7:0] byte_in;
  logic       byte_valid, byte_ready;
  logic [6:0] tail_data;
  logic [2:0] tail_count;
  logic       tail_valid, tail_ready;
  logic [6:0] code_out;
  logic       code_valid, code_ready;
  logic       done;
  logic [2:0] residue_count;

  int n_vec = 0;
  int n_err = 0;

  t05_code_unpack #(.CODE_W(7), .BYTE_W(8)) dut (
    .clk(clk), .nrst(nrst), .en(en), .clear(clear),
    .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .tail_data(tail_data), .tail_count(tail_count), .tail_valid(tail_valid),
    .tail_ready(tail_ready),
    .code_out(code_out), .code_valid(code_valid), .code_ready(code_ready),
    .done(done), .residue_count(residue_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] bytes;   // byte i at [8*i +: 8], sent first to last
    int          nb;
    logic [6:0]  tdat;
    logic [2:0]  tcnt;
    logic [55:0] codes;   // code i at [7*i +: 7]
    int          nc;
    logic [2:0]  res;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic run_stream(input int idx, input vec_t v);
    int          bi = 0;
    int          nc = 0;
    int          guard = 0;
    bit          tail_sent = 1'b0;
    bit          got_done = 1'b0;
    logic [63:0] bsh;
    logic [55:0] csh;
    code_ready = 1'b1;
    while (!got_done && guard < 300) begin
      @(negedge clk);
      bsh        = v.bytes >> (8 * bi);
      byte_valid = (bi < v.nb);
      byte_in    = bsh[7:0];
      tail_valid = !tail_sent;
      tail_data  = v.tdat;
      tail_count = v.tcnt;
      #1;
      if (done) begin
        got_done = 1'b1;
        chk($sformatf("v%0d residue", idx), residue_count, v.res);
      end else begin
        if (code_valid && code_ready) begin
          csh = v.codes >> (7 * nc);
          if (nc < v.nc) chk($sformatf("v%0d code%0d", idx, nc), code_out, csh[6:0]);
          nc++;
        end
        if (byte_valid && byte_ready) bi++;
        if (tail_valid && tail_ready) begin
          chk($sformatf("v%0d tail_after_bytes", idx), bi, v.nb);
          tail_sent = 1'b1;
        end
      end
      guard++;
    end
    byte_valid = 1'b0;
    tail_valid = 1'b0;
    chk($sformatf("v%0d done_seen", idx), got_done, 1);
    chk($sformatf("v%0d code_count", idx), nc, v.nc);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int acc;
    nrst = 1'b0; en = 1'b1; clear = 1'b0;
    byte_in = '0; byte_valid = 1'b0;
    tail_data = '0; tail_count = '0; tail_valid = 1'b0;
    code_ready = 1'b0;

    vecs[0] = '{64'h83, 1, 7'h02, 3'd6, {42'd0, 7'h42, 7'h41}, 2, 3'd0};
    vecs[1] = '{64'h00FF_FFFF_FFFF_FFFF, 7, 7'h00, 3'd0, {8{7'h7F}}, 8, 3'd0};
    vecs[2] = '{64'hAA, 1, 7'h05, 3'd3, {49'd0, 7'h55}, 1, 3'd4};
    vecs[3] = '{64'h00, 1, 7'h3F, 3'd6, {42'd0, 7'h3F, 7'h00}, 2, 3'd0};
    vecs[4] = '{64'h3412, 2, 7'h01, 3'd1, {42'd0, 7'h0D, 7'h09}, 2, 3'd3};

    #12;
    chk("rst code_valid", code_valid, 0);
    chk("rst code_out", code_out, 0);
    chk("rst done", done, 0);
    chk("rst residue", residue_count, 0);
    chk("rst byte_ready", byte_ready, 0);
    chk("rst tail_ready", tail_ready, 0);
    @(negedge clk);
    nrst = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 5; i++) run_stream(i, vecs[i]);
    @(negedge clk); #1;
    chk("residue_hold", residue_count, 3);

    // backpressure on a pending code, with an enable-low hold in the middle
    code_ready = 1'b0;
    @(negedge clk); byte_valid = 1'b1; byte_in = 8'hFF; #1;
    chk("bp byte_ready", byte_ready, 1);
    @(negedge clk); byte_in = 8'h00;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk($sformatf("bp%0d valid", k), code_valid, 1);
      chk($sformatf("bp%0d code", k), code_out, 7'h7F);
      chk($sformatf("bp%0d byte_blocked", k), byte_ready, 0);
      @(negedge clk);
    end
    byte_valid = 1'b0; en = 1'b0; code_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      #1;
      chk($sformatf("en_hold%0d valid", k), code_valid, 1);
      chk($sformatf("en_hold%0d code", k), code_out, 7'h7F);
      @(negedge clk);
    end
    en = 1'b1; #1;
    chk("bp release code", {code_valid, code_out}, {1'b1, 7'h7F});
    @(negedge clk); tail_valid = 1'b1; tail_data = 7'h3F; tail_count = 3'd6; #1;
    chk("bp tail_ready", tail_ready, 1);
    @(negedge clk); tail_valid = 1'b0; #1;
    chk("bp drain code", {code_valid, code_out}, {1'b1, 7'h7F});
    @(negedge clk); #1;
    chk("bp done early", done, 0);
    @(negedge clk); #1;
    chk("bp done", {done, residue_count}, {1'b1, 3'd0});
    @(negedge clk); #1;
    chk("bp done one cycle", done, 0);

    // clear with a code pending, and clear in DRAIN suppressing done
    code_ready = 1'b0;
    @(negedge clk); byte_valid = 1'b1; byte_in = 8'h55;
    @(negedge clk); byte_valid = 1'b0; #1;
    chk("clr pend code", {code_valid, code_out}, {1'b1, 7'h2A});
    clear = 1'b1; code_ready = 1'b1; #1;
    chk("clr byte_ready", byte_ready, 0);
    chk("clr tail_ready", tail_ready, 0);
    @(negedge clk); clear = 1'b0; #1;
    chk("clr code_valid", code_valid, 0);
    chk("clr empty", byte_ready, 1);
    tail_valid = 1'b1; tail_data = 7'h05; tail_count = 3'd3; #1;
    chk("clr tail_ready", tail_ready, 1);
    @(negedge clk); tail_valid = 1'b0; clear = 1'b1;
    @(negedge clk); clear = 1'b0; #1;
    chk("clr no done", done, 0);
    chk("clr back to run", byte_ready, 1);
    @(negedge clk); #1;
    chk("clr no done late", done, 0);
    run_stream(10, vecs[0]);

    // reset mid-stream with five bits buffered
    acc = 0;
    code_ready = 1'b1;
    for (int k = 0; k < 40 && acc < 5; k++) begin
      @(negedge clk); byte_valid = 1'b1; byte_in = 8'h83; #1;
      if (byte_ready) acc++;
    end
    chk("rst_mid fill", acc, 5);
    @(negedge clk); byte_valid = 1'b0; #1;
    chk("rst_mid cnt12 valid", code_valid, 1);
    @(negedge clk); #1;
    chk("rst_mid cnt5 valid", code_valid, 0);
    chk("rst_mid cnt5 ready", byte_ready, 1);
    nrst = 1'b0; #1;
    chk("rst_mid code_valid", code_valid, 0);
    chk("rst_mid code_out", code_out, 0);
    chk("rst_mid done", done, 0);
    chk("rst_mid residue", residue_count, 0);
    chk("rst_mid byte_ready", byte_ready, 0);
    chk("rst_mid tail_ready", tail_ready, 0);
    @(negedge clk); nrst = 1'b1; #1;
    chk("rst_rel before edge", byte_ready, 0);
    @(negedge clk); #1;
    chk("rst_rel first cycle", byte_ready, 1);
    run_stream(11, vecs[0]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
